uart_tx_ctrl: RTL and testbench

Serial UART transmitter for the board's outbound link. It accepts a one-cycle start pulse, which is normally the debounced button event, together with a parallel byte. It then shifts out a standard 8N1 frame, LSB first, on o_tx at a fixed baud rate derived from the 100 MHz system clock. It is the transmit end of the UART path and pairs with the board-side receiver.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/baud_tick_gen.sv | 38 +++
 rtl/uart_tx_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default oversampling and baud divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    // Clocks per oversample tick; integer truncation is intentional.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick divider: tick is high for the last clock of every DIV-clock period.
// A synchronous clear restarts the period so the first tick lands exactly DIV clocks later.
module baud_tick_gen #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic tick_next_c
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    // tick_next_c previews tick so callers can register outputs that align with it.
    always_comb begin
        cnt_n       = (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + 1'b1;
        tick_next_c = (cnt_n == CNT_W'(DIV - 1));
        if (clear) begin
            cnt_n       = '0;
            tick_next_c = (DIV == 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_n;
            tick <= tick_next_c;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: 8N1 frames, LSB first, each bit OVERSAMPLE*DIV clocks long.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    uart_state_t          state;
    uart_state_t          state_n;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_n;
    logic [TICK_W-1:0]    tick_cnt;
    logic [TICK_W-1:0]    tick_cnt_n;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_cnt_n;
    logic                 tx_n;
    logic                 busy_n;
    logic                 done_n;
    logic                 div_clear_c;
    logic                 tick;
    logic                 tick_next_c;
    logic                 bit_end_c;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
    logic                 parity_n;
`endif

    baud_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk         (clk),
        .reset       (reset),
        .clear       (div_clear_c),
        .tick        (tick),
        .tick_next_c (tick_next_c)
    );

    assign bit_end_c = tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));

    // Next-state and next-output logic; o_tx/o_busy/o_done are registered from tx_n/busy_n/done_n.
    always_comb begin
        state_n     = state;
        shift_n     = shift;
        tick_cnt_n  = tick_cnt;
        bit_cnt_n   = bit_cnt;
        tx_n        = o_tx;
        busy_n      = o_busy;
        done_n      = 1'b0;
        div_clear_c = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n    = parity;
`endif

        if (state != IDLE && tick) begin
            tick_cnt_n = bit_end_c ? '0 : tick_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (i_start) begin
                    state_n     = START;
                    shift_n     = i_data;
                    tick_cnt_n  = '0;
                    bit_cnt_n   = '0;
                    div_clear_c = 1'b1;
                    tx_n        = 1'b0;
                    busy_n      = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_n    = ^i_data;
`endif
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_n = DATA;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n   = PARITY;
                        tx_n      = parity;
`else
                        state_n   = STOP;
                        tx_n      = 1'b1;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        tx_n      = shift_n[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                // Done lands on the final clock of the stop bit, one clock before the IDLE return.
                done_n = tick_next_c && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
                if (bit_end_c) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            o_tx     <= tx_n;
            o_busy   <= busy_n;
            o_done   <= done_n;
`ifdef UART_TX_PARITY_EN
            parity   <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus predicts accepted frames, a line monitor decodes o_tx.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int unsigned CLK_FREQ   = 1_600_000;
    localparam int unsigned BAUD       = 10_000;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned BIT_CLKS   = (CLK_FREQ / (BAUD * OVERSAMPLE)) * OVERSAMPLE;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = DATA_BITS + 3;
`else
    localparam int unsigned NBITS = DATA_BITS + 2;
`endif
    localparam int unsigned FRAME = NBITS * BIT_CLKS;

    typedef struct {
        logic [7:0]  data;
        int unsigned edge_idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    int unsigned cyc = 0;
    int unsigned free_edge = 0;
    int unsigned last_accept = 0;
    int          errors = 0;
    int          checks = 0;
    logic        mon_active = 1'b0;
    exp_t        exp_q[$];

    uart_tx_ctrl #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_data  (i_data),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Line level of frame bit idx for a byte: start, data LSB first, optional even parity, stop.
    function automatic logic exp_level(input logic [7:0] d, input int unsigned idx);
        if (idx == 0) return 1'b0;
        if (idx <= DATA_BITS) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == DATA_BITS + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // One clock of stimulus; the model accepts a start only once the previous frame has fully ended.
    task automatic drive_cycle(input logic s, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        i_start = s;
        i_data  = d;
        if (s && !reset && cyc >= free_edge) begin
            e.data     = d;
            e.edge_idx = cyc;
            exp_q.push_back(e);
            last_accept = cyc;
            free_edge   = cyc + FRAME + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 8'($urandom()));
    endtask

    // Line monitor: decodes each frame from the falling start edge and scores it against the queue.
    initial begin : monitor
        logic prev_tx;
        exp_t cur;
        int   k;
        int   done_cnt;
        int   done_pos;
        int   busy_cnt;
        int   bad_cnt;
        prev_tx  = 1'b1;
        k        = 0;
        done_cnt = 0;
        done_pos = -1;
        busy_cnt = 0;
        bad_cnt  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
                prev_tx    = 1'b1;
            end else begin
                if (!mon_active && prev_tx && !o_tx) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check($sformatf("start_latency_%02h", cur.data), int'(cyc), int'(cur.edge_idx + 1));
                        mon_active = 1'b1;
                        k = 0; done_cnt = 0; done_pos = -1; busy_cnt = 0; bad_cnt = 0;
                    end
                end else if (!mon_active && o_done) begin
                    check("spurious_done", 1, 0);
                end
                if (mon_active) begin
                    if (k < int'(FRAME)) begin
                        if (o_tx !== exp_level(cur.data, k / BIT_CLKS)) bad_cnt++;
                        if (o_busy === 1'b1) busy_cnt++;
                        if (o_done === 1'b1) begin
                            done_cnt++;
                            done_pos = k;
                        end
                        if ((k % BIT_CLKS) == BIT_CLKS - 1) begin
                            check($sformatf("frame_%02h_bit%0d_bad_clocks", cur.data, k / BIT_CLKS), bad_cnt, 0);
                            bad_cnt = 0;
                        end
                        k++;
                    end else begin
                        check($sformatf("busy_clocks_%02h", cur.data), busy_cnt, int'(FRAME));
                        check($sformatf("done_count_%02h", cur.data), done_cnt, 1);
                        check($sformatf("done_pos_%02h", cur.data), done_pos, int'(FRAME) - 1);
                        check($sformatf("idle_gap_tx_busy_done_%02h", cur.data), int'({o_tx, o_busy, o_done}), 4);
                        mon_active = 1'b0;
                    end
                end
                prev_tx = o_tx;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] d;
        int         len;
        int         gap;
        int         spur;

        // Reset state
        repeat (5) @(negedge clk);
        check("reset_tx", int'(o_tx), 1);
        check("reset_busy", int'(o_busy), 0);
        check("reset_done", int'(o_done), 0);
        reset = 1'b0;

        // Reset mid-frame at clock 400 (line is low in bit 2 of 0x00)
        idle(3);
        drive_cycle(1'b1, 8'h00);
        idle(400);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midframe_reset_tx", int'(o_tx), 1);
        check("midframe_reset_busy", int'(o_busy), 0);
        check("midframe_reset_done", int'(o_done), 0);
        exp_q.delete();
        free_edge = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(5);

        // Fresh full frame after reset, then 0x55 with back-to-back 0x0F on the first idle cycle
        drive_cycle(1'b1, 8'hC6);
        idle(FRAME + 20);
        drive_cycle(1'b1, 8'h55);
        idle(FRAME);
        drive_cycle(1'b1, 8'h0F);
        idle(FRAME + 20);

        // Start ignored while busy
        drive_cycle(1'b1, 8'hA3);
        idle(499);
        drive_cycle(1'b1, 8'hFF);
        idle(FRAME + 200);

        // Data changes after acceptance
        drive_cycle(1'b1, 8'h81);
        drive_cycle(1'b0, 8'h00);
        idle(FRAME + 20);

        // Parity patterns
        drive_cycle(1'b1, 8'h07);
        idle(FRAME + 20);
        drive_cycle(1'b1, 8'h03);
        idle(FRAME + 20);

        // Start held high across a whole frame restarts on the first idle cycle
        repeat (FRAME + 5) drive_cycle(1'b1, 8'h3C);
        idle(FRAME + 20);

        // Random bytes, pulse lengths, gaps and stray mid-frame pulses
        for (int r = 0; r < 12; r++) begin
            d    = 8'($urandom());
            len  = int'($urandom_range(1, 3));
            gap  = int'($urandom_range(0, 2200));
            spur = int'($urandom_range(0, gap));
            repeat (len) drive_cycle(1'b1, d);
            idle(spur);
            drive_cycle(1'b1, 8'($urandom()));
            idle(gap - spur);
        end

        // Drain, then make sure no further frame appears
        for (int n = 0; n < int'(2 * FRAME) && (exp_q.size() > 0 || mon_active); n++) idle(1);
        check("drain_queue_left", exp_q.size(), 0);
        check("drain_monitor_active", int'(mon_active), 0);
        idle(3000);
        check("final_queue_left", exp_q.size(), 0);
        check("final_tx_idle", int'(o_tx), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
